audio_frame_pingpong: RTL and testbench
=======================================

Name: audio_frame_pingpong

Overview:
Parametrised capture buffer between the ADC serial-to-parallel driver and the UDP transmitter. Collects channel-interleaved samples into a two-bank ping-pong RAM and keeps every frame channel-aligned, so channel 0 is always at address 0. Hands each full bank to the packet sender through a ready/ack handshake and counts samples dropped while both banks are busy. Replaces the free-running, single-bank, two-channel write-address logic, whose writes run unchecked into a RAM the sender may be reading.

Parameters:
SAMPLE_W, 32, sample width in bits.
NUM_CH, 2, interleaved channel count (≥1).
FRAME_SAMPLES, 2048, samples per bank; must be a multiple of NUM_CH and ≥2.
SEQ_W, 16, width of the frame sequence number.
OVF_W, 16, width of the overflow counter.
Derived: ADDR_W = clog2(FRAME_SAMPLES); CH_W = max(1, clog2(NUM_CH)).

Ports:
fpga_gclk  in  1  system clock; all logic in this domain.
reset_n  in  1  asynchronous, active-low reset.
enable  in  1  capture enable, level.
sample_valid  in  1  one-cycle strobe per sample.
sample_chan  in  CH_W  channel index of sample_data.
sample_data  in  SAMPLE_W  sample value.
frame_ready  out  1  a full bank is available to read.
frame_bank  out  1  index of the presented bank.
frame_seq  out  SEQ_W  sequence number of the presented frame.
frame_ack  in  1  one-cycle pulse: presented bank has been consumed.
rd_addr  in  ADDR_W  read address within the presented bank.
rd_data  out  SAMPLE_W  registered read data.
sync_err  out  1  one-cycle pulse on a channel-order violation.
overflow_cnt  out  OVF_W  samples dropped because no bank was free; saturating.
busy  out  1  state is not IDLE.

Behaviour:
- Reset (asynchronous): all outputs 0. State IDLE. wr_bank=0, rd_bank=0, wr_addr=0, exp_ch=0, full[1:0]=0. RAM contents are undefined.
- Write side FSM states: IDLE, SYNC, FILL, WAIT_BANK.
  - IDLE: on enable=1, go to SYNC.
  - SYNC: discard samples until sample_valid with sample_chan==0. That sample is written at wr_addr 0, wr_addr becomes 1, exp_ch becomes 1 mod NUM_CH, and the FSM goes to FILL.
  - FILL, sample_valid with sample_chan==exp_ch: write mem[wr_bank][wr_addr], wr_addr+1, exp_ch+1 mod NUM_CH.
  - FILL, sample_valid with sample_chan!=exp_ch: do not write; pulse sync_err; wr_addr=0; go to SYNC. The partial bank is abandoned.
  - Last address written (wr_addr==FRAME_SAMPLES-1): set full[wr_bank]. If the other bank is free, or is acked in this same cycle: toggle wr_bank, wr_addr=0, stay in FILL. Otherwise go to WAIT_BANK.
  - WAIT_BANK: every sample_valid increments overflow_cnt, saturating at all-ones. When the other bank is freed: toggle wr_bank, wr_addr=0, go to SYNC.
  - enable=0 in any state: go to IDLE on the next edge and clear wr_addr and exp_ch. full flags, rd_bank and frame_seq are kept, so pending frames can still be drained.
- Read side:
  - frame_ready = full[rd_bank]; frame_bank = rd_bank.
  - Accepted frame_ack (frame_ack & frame_ready): clear full[rd_bank], toggle rd_bank, frame_seq+1 (wraps modulo 2^SEQ_W).
  - frame_ack while frame_ready=0 is ignored.
  - frame_ready can re-assert on the cycle after an ack if the other bank is already full.
- Bank ordering: banks always fill and drain alternately, so rd_bank never overtakes wr_bank.
- rd_data = mem[rd_bank][rd_addr], registered, 1-cycle latency. A same-cycle write never targets the presented bank, so there is no read/write collision.
- Simultaneous events: a bank completing and an ack in the same cycle are both applied; the freed bank is used immediately with no overflow. A sample arriving in the same cycle enable falls is ignored.
- Reset mid-frame discards all buffered frames.

Decomposition:
- Package audio_cap_pkg: write FSM state enum (IDLE, SYNC, FILL, WAIT_BANK) and the helper functions for ADDR_W/CH_W derivation.
- Sub-module pingpong_ram: simple dual-port, 2*FRAME_SAMPLES x SAMPLE_W, inferred, with bank bit as the address MSB and a registered read port.

Test Plan (NUM_CH=2, FRAME_SAMPLES=8, SEQ_W=2, OVF_W=3 unless noted):
1. Enable, then chan 1 (0xAA), then chan 0/1 pairs data 0..7 -> 0xAA dropped. frame_ready=1, frame_bank=0, frame_seq=0. rd_addr 0..7 returns 0..7, one cycle later each.
2. After 3 good samples, a chan-0 sample arrives where chan 1 is expected -> sync_err for exactly 1 cycle. The next chan-0 sample (0x55) lands at address 0, confirmed on readback.
3. No ack, 16 good samples plus 9 more -> both banks full, overflow_cnt saturates at 7, busy=1. Ack -> frame_bank=1, frame_seq=1. The next chan-0 sample goes to bank 0, address 0.
4. Bank 1 completes in the same cycle as the ack of bank 0 -> no overflow increment. Subsequent samples are written into bank 0 with no gap.
5. Four accepted acks -> frame_seq sequence 1,2,3,0 (wrap). An ack with frame_ready=0 leaves seq and rd_bank unchanged.
6. reset_n low mid-fill, asynchronously between clock edges -> all outputs 0 immediately. After release and a full frame, frame_seq=0 and frame_bank=0.

Source files
------------

// File: rtl/audio_cap_pkg.sv
// Shared types and width helpers for the audio capture ping-pong buffer.
package audio_cap_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SYNC,
        FILL,
        WAIT_BANK
    } wr_state_e;

    function automatic int calc_addr_w(input int frame_samples);
        return (frame_samples > 1) ? $clog2(frame_samples) : 1;
    endfunction

    function automatic int calc_ch_w(input int num_ch);
        return (num_ch > 1) ? $clog2(num_ch) : 1;
    endfunction

endpackage

// File: rtl/pingpong_ram.sv
// Two-bank simple dual-port sample RAM; the bank bit is the address MSB, read port registered.
module pingpong_ram #(
    parameter int SAMPLE_W = 32,
    parameter int ADDR_W   = 11
) (
    input  logic                clk_i,
    input  logic                rst_n_i,
    input  logic                we_i,
    input  logic                wr_bank_i,
    input  logic [ADDR_W-1:0]   wr_addr_i,
    input  logic [SAMPLE_W-1:0] wr_data_i,
    input  logic                rd_bank_i,
    input  logic [ADDR_W-1:0]   rd_addr_i,
    output logic [SAMPLE_W-1:0] rd_data_o
);

    logic [SAMPLE_W-1:0] mem_q [2**(ADDR_W+1)];
    logic [SAMPLE_W-1:0] rd_data_q;

    // NOTE: the array has no reset so it maps onto block RAM; only the output register is cleared.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[{wr_bank_i, wr_addr_i}] <= wr_data_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= mem_q[{rd_bank_i, rd_addr_i}];
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/audio_frame_pingpong.sv
// Channel-aligned capture of interleaved ADC samples into a ping-pong RAM,
// handing each full bank to the packet sender through a ready/ack handshake.
module audio_frame_pingpong
    import audio_cap_pkg::*;
#(
    parameter int SAMPLE_W      = 32,
    parameter int NUM_CH        = 2,
    parameter int FRAME_SAMPLES = 2048,
    parameter int SEQ_W         = 16,
    parameter int OVF_W         = 16,
    localparam int ADDR_W       = calc_addr_w(FRAME_SAMPLES),
    localparam int CH_W         = calc_ch_w(NUM_CH)
) (
    input  logic                fpga_gclk,
    input  logic                reset_n,
    input  logic                enable,
    input  logic                sample_valid,
    input  logic [CH_W-1:0]     sample_chan,
    input  logic [SAMPLE_W-1:0] sample_data,
    output logic                frame_ready,
    output logic                frame_bank,
    output logic [SEQ_W-1:0]    frame_seq,
    input  logic                frame_ack,
    input  logic [ADDR_W-1:0]   rd_addr,
    output logic [SAMPLE_W-1:0] rd_data,
    output logic                sync_err,
    output logic [OVF_W-1:0]    overflow_cnt,
    output logic                busy
);

    localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(FRAME_SAMPLES - 1);
    localparam logic [CH_W-1:0]   LAST_CH    = CH_W'(NUM_CH - 1);
    localparam logic [CH_W-1:0]   CH_AFTER_0 = (NUM_CH > 1) ? CH_W'(1) : CH_W'(0);

    wr_state_e         state_q, state_d;
    logic              wr_bank_q, wr_bank_d;
    logic              rd_bank_q, rd_bank_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [CH_W-1:0]   exp_ch_q, exp_ch_d;
    logic [1:0]        full_q, full_d;
    logic [SEQ_W-1:0]  seq_q, seq_d;
    logic [OVF_W-1:0]  ovf_q, ovf_d;
    logic              sync_err_q, sync_err_d;

    logic              we;
    logic [ADDR_W-1:0] we_addr;
    logic              ack_acc;
    logic              other_free;
    logic [CH_W-1:0]   next_ch;

    assign ack_acc    = frame_ack & full_q[rd_bank_q];
    // The bank we would switch to is usable if empty, or if the sender releases it this very cycle.
    assign other_free = !full_q[~wr_bank_q] || (ack_acc && (rd_bank_q != wr_bank_q));
    assign next_ch    = (exp_ch_q == LAST_CH) ? CH_W'(0) : exp_ch_q + CH_W'(1);

    // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
    always_comb begin
        state_d    = state_q;
        wr_bank_d  = wr_bank_q;
        rd_bank_d  = rd_bank_q;
        wr_addr_d  = wr_addr_q;
        exp_ch_d   = exp_ch_q;
        full_d     = full_q;
        seq_d      = seq_q;
        ovf_d      = ovf_q;
        sync_err_d = 1'b0;
        we         = 1'b0;
        we_addr    = wr_addr_q;

        if (ack_acc) begin
            full_d[rd_bank_q] = 1'b0;
            rd_bank_d         = ~rd_bank_q;
            seq_d             = seq_q + SEQ_W'(1);
        end

        if (!enable) begin
            state_d   = IDLE;
            wr_addr_d = '0;
            exp_ch_d  = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    // Disabled while blocked: the write bank still holds an unsent frame.
                    if (full_q[wr_bank_q]) begin
                        if (other_free) begin
                            wr_bank_d = ~wr_bank_q;
                            state_d   = SYNC;
                        end else begin
                            state_d = WAIT_BANK;
                        end
                    end else begin
                        state_d = SYNC;
                    end
                end
                SYNC: begin
                    if (sample_valid && sample_chan == '0) begin
                        we        = 1'b1;
                        we_addr   = '0;
                        wr_addr_d = ADDR_W'(1);
                        exp_ch_d  = CH_AFTER_0;
                        state_d   = FILL;
                    end
                end
                FILL: begin
                    if (sample_valid) begin
                        if (sample_chan == exp_ch_q) begin
                            we       = 1'b1;
                            exp_ch_d = next_ch;
                            if (wr_addr_q == LAST_ADDR) begin
                                full_d[wr_bank_q] = 1'b1;
                                wr_addr_d         = '0;
                                if (other_free) begin
                                    wr_bank_d = ~wr_bank_q;
                                end else begin
                                    state_d = WAIT_BANK;
                                end
                            end else begin
                                wr_addr_d = wr_addr_q + ADDR_W'(1);
                            end
                        end else begin
                            sync_err_d = 1'b1;
                            wr_addr_d  = '0;
                            state_d    = SYNC;
                        end
                    end
                end
                WAIT_BANK: begin
                    if (sample_valid && ovf_q != '1) begin
                        ovf_d = ovf_q + OVF_W'(1);
                    end
                    if (other_free) begin
                        wr_bank_d = ~wr_bank_q;
                        wr_addr_d = '0;
                        state_d   = SYNC;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // NOTE: state registers use non-blocking assignments so all updates land together at the edge.
    always_ff @(posedge fpga_gclk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            wr_bank_q  <= 1'b0;
            rd_bank_q  <= 1'b0;
            wr_addr_q  <= '0;
            exp_ch_q   <= '0;
            full_q     <= '0;
            seq_q      <= '0;
            ovf_q      <= '0;
            sync_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_bank_q  <= wr_bank_d;
            rd_bank_q  <= rd_bank_d;
            wr_addr_q  <= wr_addr_d;
            exp_ch_q   <= exp_ch_d;
            full_q     <= full_d;
            seq_q      <= seq_d;
            ovf_q      <= ovf_d;
            sync_err_q <= sync_err_d;
        end
    end

    pingpong_ram #(
        .SAMPLE_W (SAMPLE_W),
        .ADDR_W   (ADDR_W)
    ) u_ram (
        .clk_i     (fpga_gclk),
        .rst_n_i   (reset_n),
        .we_i      (we),
        .wr_bank_i (wr_bank_q),
        .wr_addr_i (we_addr),
        .wr_data_i (sample_data),
        .rd_bank_i (rd_bank_q),
        .rd_addr_i (rd_addr),
        .rd_data_o (rd_data)
    );

    assign frame_ready  = full_q[rd_bank_q];
    assign frame_bank   = rd_bank_q;
    assign frame_seq    = seq_q;
    assign overflow_cnt = ovf_q;
    assign sync_err     = sync_err_q;
    assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_audio_frame_pingpong.sv
// Self-checking bench: directed scenarios plus randomized traffic against a frame-queue reference model.
module tb_audio_frame_pingpong;

    localparam int SW  = 32;
    localparam int NCH = 2;
    localparam int FS  = 8;
    localparam int SQW = 2;
    localparam int OW  = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          enable = 1'b0;
    logic          sample_valid = 1'b0;
    logic [0:0]    sample_chan = '0;
    logic [SW-1:0] sample_data = '0;
    logic          frame_ready;
    logic          frame_bank;
    logic [SQW-1:0] frame_seq;
    logic          frame_ack = 1'b0;
    logic [2:0]    rd_addr = '0;
    logic [SW-1:0] rd_data;
    logic          sync_err;
    logic [OW-1:0] overflow_cnt;
    logic          busy;
    logic [8:0]    status;

    always #5 clk = ~clk;

    assign status = {frame_ready, frame_bank, frame_seq, overflow_cnt, busy, sync_err};

    audio_frame_pingpong #(
        .SAMPLE_W      (SW),
        .NUM_CH        (NCH),
        .FRAME_SAMPLES (FS),
        .SEQ_W         (SQW),
        .OVF_W         (OW)
    ) dut (
        .fpga_gclk    (clk),
        .reset_n      (rst_n),
        .enable       (enable),
        .sample_valid (sample_valid),
        .sample_chan  (sample_chan),
        .sample_data  (sample_data),
        .frame_ready  (frame_ready),
        .frame_bank   (frame_bank),
        .frame_seq    (frame_seq),
        .frame_ack    (frame_ack),
        .rd_addr      (rd_addr),
        .rd_data      (rd_data),
        .sync_err     (sync_err),
        .overflow_cnt (overflow_cnt),
        .busy         (busy)
    );

    // Reference model: completed frames waiting for the sender plus the frame under construction.
    typedef logic [SW-1:0] frame_t [FS];
    frame_t        m_frames[$];
    logic [SW-1:0] m_part[$];
    int            m_ovf;
    int            m_acks;
    bit            m_active;
    bit            m_synced;
    bit            m_blocked;
    bit            m_err;
    bit            m_rd_valid;
    logic [SW-1:0] m_rd_exp;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic model_reset();
        m_frames.delete();
        m_part.delete();
        m_ovf = 0; m_acks = 0;
        m_active = 0; m_synced = 0; m_blocked = 0; m_err = 0;
        m_rd_valid = 0; m_rd_exp = '0;
    endtask

    task automatic model_step(input bit en, input bit v, input bit ch,
                              input logic [SW-1:0] d, input bit ack, input int addr);
        int     acc;
        frame_t f;
        m_rd_valid = (m_frames.size() > 0);
        if (m_rd_valid) m_rd_exp = m_frames[0][addr];
        acc   = (ack && m_frames.size() > 0) ? 1 : 0;
        m_err = 0;
        if (!en) begin
            m_active = 0; m_synced = 0; m_part.delete();
        end else if (!m_active) begin
            m_active = 1; m_synced = 0;
            if (m_blocked && (m_frames.size() - acc) < 2) m_blocked = 0;
        end else if (m_blocked) begin
            if (v && m_ovf < (2**OW - 1)) m_ovf++;
            if ((m_frames.size() - acc) < 2) begin
                m_blocked = 0; m_synced = 0;
            end
        end else if (v) begin
            if (!m_synced) begin
                if (ch == 1'b0) begin
                    m_synced = 1; m_part.push_back(d);
                end
            end else if (int'(ch) == m_part.size() % NCH) begin
                m_part.push_back(d);
            end else begin
                m_err = 1; m_synced = 0; m_part.delete();
            end
        end
        if (acc != 0) begin
            void'(m_frames.pop_front());
            m_acks++;
        end
        if (m_part.size() == FS) begin
            for (int i = 0; i < FS; i++) f[i] = m_part[i];
            m_frames.push_back(f);
            m_part.delete();
            if (m_frames.size() == 2) m_blocked = 1;
        end
    endtask

    function automatic logic [8:0] model_status();
        logic       rdy;
        logic [OW-1:0] ovf;
        rdy = (m_frames.size() > 0);
        ovf = m_ovf[OW-1:0];
        return {rdy, m_acks[0], m_acks[SQW-1:0], ovf, m_active, m_err};
    endfunction

    task automatic tick(input bit en, input bit v, input bit ch,
                        input logic [SW-1:0] d, input bit ack, input int addr);
        enable       = en;
        sample_valid = v;
        sample_chan  = ch;
        sample_data  = d;
        frame_ack    = ack;
        rd_addr      = 3'(addr);
        @(posedge clk);
        model_step(en, v, ch, d, ack, addr);
        #1;
        sample_valid = 1'b0;
        frame_ack    = 1'b0;
    endtask

    task automatic send(input bit ch, input logic [SW-1:0] d);
        tick(1'b1, 1'b1, ch, d, 1'b0, 0);
    endtask

    task automatic send_good(input logic [SW-1:0] d);
        int c;
        c = m_synced ? (m_part.size() % NCH) : 0;
        send(c[0], d);
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        enable = 1'b0; sample_valid = 1'b0; frame_ack = 1'b0; rd_addr = '0;
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        apply_reset();
        n_cmp++;
        if (status !== 9'h000) begin
            n_bad++; $display("FAIL reset_status: got %h want %h", status, 9'h000);
        end
        n_cmp++;
        if (rd_data !== '0) begin
            n_bad++; $display("FAIL reset_rd_data: got %h want 0", rd_data);
        end
    endtask

    task automatic test_aligned_frame();
        apply_reset();
        tick(1'b1, 1'b0, 1'b0, '0, 1'b0, 0);
        send(1'b1, 32'hAA);
        for (int i = 0; i < FS; i++) send(i[0], 32'(i));
        n_cmp++;
        if ({frame_ready, frame_bank, frame_seq} !== 4'b1000) begin
            n_bad++; $display("FAIL align_ready: got %b want 1000", {frame_ready, frame_bank, frame_seq});
        end
        n_cmp++;
        if (status !== model_status()) begin
            n_bad++; $display("FAIL align_status: got %h want %h", status, model_status());
        end
        for (int i = 0; i < FS; i++) begin
            tick(1'b1, 1'b0, 1'b0, '0, 1'b0, i);
            n_cmp++;
            if (rd_data !== 32'(i)) begin
                n_bad++; $display("FAIL align_read[%0d]: got %h want %h", i, rd_data, 32'(i));
            end
        end
    endtask

    task automatic test_sync_err();
        apply_reset();
        tick(1'b1, 1'b0, 1'b0, '0, 1'b0, 0);
        send(1'b0, 32'h1); send(1'b1, 32'h2); send(1'b0, 32'h3);
        send(1'b0, 32'h4);
        n_cmp++;
        if (sync_err !== 1'b1 || status !== model_status()) begin
            n_bad++; $display("FAIL sync_err_pulse: got %h want %h", status, model_status());
        end
        tick(1'b1, 1'b0, 1'b0, '0, 1'b0, 0);
        n_cmp++;
        if (sync_err !== 1'b0) begin
            n_bad++; $display("FAIL sync_err_width: got %b want 0", sync_err);
        end
        send(1'b0, 32'h55);
        for (int i = 1; i < FS; i++) send(i[0], 32'h60 + 32'(i));
        n_cmp++;
        if (frame_ready !== 1'b1) begin
            n_bad++; $display("FAIL sync_ready: got %b want 1", frame_ready);
        end
        tick(1'b1, 1'b0, 1'b0, '0, 1'b0, 0);
        n_cmp++;
        if (rd_data !== 32'h55) begin
            n_bad++; $display("FAIL sync_addr0: got %h want 00000055", rd_data);
        end
        tick(1'b1, 1'b0, 1'b0, '0, 1'b0, 1);
        n_cmp++;
        if (rd_data !== 32'h61) begin
            n_bad++; $display("FAIL sync_addr1: got %h want 00000061", rd_data);
        end
    endtask

    task automatic test_overflow();
        apply_reset();
        tick(1'b1, 1'b0, 1'b0, '0, 1'b0, 0);
        for (int i = 0; i < 2 * FS; i++) send_good($urandom);
        n_cmp++;
        if (status !== model_status()) begin
            n_bad++; $display("FAIL ovf_both_full: got %h want %h", status, model_status());
        end
        for (int i = 0; i < 9; i++) send($urandom_range(1), $urandom);
        n_cmp++;
        if (overflow_cnt !== 3'd7 || busy !== 1'b1) begin
            n_bad++; $display("FAIL ovf_saturate: got cnt=%0d busy=%b want cnt=7 busy=1", overflow_cnt, busy);
        end
        tick(1'b1, 1'b0, 1'b0, '0, 1'b1, 0);
        n_cmp++;
        if ({frame_ready, frame_bank, frame_seq} !== 4'b1101) begin
            n_bad++; $display("FAIL ovf_ack: got %b want 1101", {frame_ready, frame_bank, frame_seq});
        end
        send(1'b0, 32'h1234);
        for (int i = 1; i < FS; i++) send_good($urandom);
        tick(1'b1, 1'b0, 1'b0, '0, 1'b1, 0);
        n_cmp++;
        if (status !== model_status()) begin
            n_bad++; $display("FAIL ovf_refill: got %h want %h", status, model_status());
        end
        tick(1'b1, 1'b0, 1'b0, '0, 1'b0, 0);
        n_cmp++;
        if (rd_data !== 32'h1234) begin
            n_bad++; $display("FAIL ovf_bank0_addr0: got %h want 00001234", rd_data);
        end
    endtask

    task automatic test_back_to_back();
        apply_reset();
        tick(1'b1, 1'b0, 1'b0, '0, 1'b0, 0);
        for (int i = 0; i < 2 * FS - 1; i++) send_good($urandom);
        tick(1'b1, 1'b1, 1'b1, $urandom, 1'b1, 0);
        n_cmp++;
        if (overflow_cnt !== 3'd0 || frame_bank !== 1'b1 || status !== model_status()) begin
            n_bad++; $display("FAIL b2b_ack: got %h want %h", status, model_status());
        end
        for (int i = 0; i < FS; i++) send_good($urandom);
        n_cmp++;
        if (status !== model_status() || overflow_cnt !== 3'd0) begin
            n_bad++; $display("FAIL b2b_nogap: got %h want %h", status, model_status());
        end
        tick(1'b1, 1'b0, 1'b0, '0, 1'b1, 0);
        for (int i = 0; i < FS; i++) begin
            tick(1'b1, 1'b0, 1'b0, '0, 1'b0, i);
            n_cmp++;
            if (!m_rd_valid || rd_data !== m_rd_exp) begin
                n_bad++; $display("FAIL b2b_read[%0d]: got %h want %h", i, rd_data, m_rd_exp);
            end
        end
    endtask

    task automatic test_seq_wrap();
        logic [SQW-1:0] exp_seq [4];
        exp_seq = '{2'd1, 2'd2, 2'd3, 2'd0};
        apply_reset();
        tick(1'b1, 1'b0, 1'b0, '0, 1'b0, 0);
        for (int k = 0; k < 4; k++) begin
            for (int i = 0; i < FS; i++) send_good($urandom);
            tick(1'b1, 1'b0, 1'b0, '0, 1'b1, 0);
            n_cmp++;
            if (frame_seq !== exp_seq[k] || frame_ready !== 1'b0) begin
                n_bad++; $display("FAIL seq_wrap[%0d]: got seq=%0d rdy=%b want seq=%0d rdy=0",
                                  k, frame_seq, frame_ready, exp_seq[k]);
            end
        end
        tick(1'b1, 1'b0, 1'b0, '0, 1'b1, 0);
        n_cmp++;
        if ({frame_bank, frame_seq} !== 3'b000) begin
            n_bad++; $display("FAIL seq_idle_ack: got %b want 000", {frame_bank, frame_seq});
        end
    endtask

    task automatic test_async_reset();
        apply_reset();
        tick(1'b1, 1'b0, 1'b0, '0, 1'b0, 0);
        for (int i = 0; i < FS + 3; i++) send_good(32'(i + 1));
        tick(1'b1, 1'b0, 1'b0, '0, 1'b0, 2);
        n_cmp++;
        if (rd_data !== 32'd3 || frame_ready !== 1'b1) begin
            n_bad++; $display("FAIL areset_pre: got data=%h rdy=%b want 3/1", rd_data, frame_ready);
        end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({status, rd_data} !== '0) begin
            n_bad++; $display("FAIL areset_outputs: got %h/%h want 0/0", status, rd_data);
        end
        model_reset();
        #2 rst_n = 1'b1;
        tick(1'b1, 1'b0, 1'b0, '0, 1'b0, 0);
        for (int i = 0; i < FS; i++) send_good($urandom);
        n_cmp++;
        if ({frame_ready, frame_bank, frame_seq} !== 4'b1000) begin
            n_bad++; $display("FAIL areset_after: got %b want 1000", {frame_ready, frame_bank, frame_seq});
        end
    endtask

    task automatic test_random();
        bit en, v, ch, ack;
        int c;
        apply_reset();
        for (int n = 0; n < 800; n++) begin
            en  = (n < 2) || ($urandom_range(99) >= 2);
            v   = ($urandom_range(99) < 60);
            c   = (m_synced && !m_blocked && $urandom_range(99) < 92) ?
                  (m_part.size() % NCH) : int'($urandom_range(1));
            ch  = c[0];
            ack = ($urandom_range(99) < 12);
            tick(en, v, ch, $urandom, ack, int'($urandom_range(FS - 1)));
            n_cmp++;
            if (status !== model_status()) begin
                n_bad++; $display("FAIL rand_status@%0d: got %h want %h", n, status, model_status());
            end
            if (m_rd_valid) begin
                n_cmp++;
                if (rd_data !== m_rd_exp) begin
                    n_bad++; $display("FAIL rand_rd_data@%0d: got %h want %h", n, rd_data, m_rd_exp);
                end
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_aligned_frame();
        test_sync_err();
        test_overflow();
        test_back_to_back();
        test_seq_wrap();
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
